// File: rtl/axi_burst_pkg.sv
// Shared AXI encodings, fixed AR attributes and FSM state type for the burst reader.
package axi_burst_pkg;

    localparam logic [1:0] BurstFixed     = 2'b00;
    localparam logic [1:0] BurstIncr      = 2'b01;
    localparam logic [1:0] LockNormal     = 2'b00;
    // Normal non-cacheable bufferable.
    localparam logic [3:0] CacheNormNcBuf = 4'b0011;
    localparam logic [2:0] ProtDefault    = 3'b000;
    localparam logic [3:0] QosDefault     = 4'b0000;
    localparam logic [3:0] RegionDefault  = 4'b0000;

    // AXI4 caps FIXED bursts at 16 beats; INCR bursts may not cross a 4 KB page.
    localparam int unsigned FixedMaxBeats = 16;
    localparam int unsigned BoundaryBytes = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // AxSIZE encoding (log2 of bytes per beat) for a given data bus width.
    function automatic logic [2:0] calc_arsize(input int unsigned data_width);
        logic [2:0] size;
        size = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((data_width / 8) == (32'd1 << i)) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/axi_burst_reader_if.sv
// AXI4 read address and read data channels as seen by the burst reader.
interface axi_burst_reader_if #(
    parameter int unsigned C_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_AXI_DATA_WIDTH = 32
);
    logic [C_AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic [1:0]                  arlock;
    logic [3:0]                  arcache;
    logic [2:0]                  arprot;
    logic [3:0]                  arqos;
    logic [3:0]                  arregion;
    logic                        arvalid;
    logic                        arready;
    logic [C_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        output arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        input  arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_burst_len_calc.sv
// Beats in the next burst: mode cap (FIXED 16, INCR max length / 4 KB page), clamped to remaining.
module axi_burst_len_calc
    import axi_burst_pkg::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_MAX_BURST_LEN  = 256,
    parameter int unsigned C_LEN_WIDTH      = 16
) (
    input  logic [11:0]            addr_offset,
    input  logic [C_LEN_WIDTH-1:0] remaining,
    input  logic                   fixed,
    output logic [8:0]             burst_len
);

    localparam int unsigned SizeLog = 32'(calc_arsize(C_AXI_DATA_WIDTH));

    logic [31:0] to_boundary;
    logic [8:0]  cap;

    // Pick the per-mode cap, then never exceed what is left of the command.
    always_comb begin
        to_boundary = (32'(BoundaryBytes) - 32'(addr_offset)) >> SizeLog;
        if (fixed) begin
            cap = 9'(FixedMaxBeats);
        end else if (to_boundary < 32'(C_MAX_BURST_LEN)) begin
            cap = 9'(to_boundary);
        end else begin
            cap = 9'(C_MAX_BURST_LEN);
        end
        if (32'(remaining) < 32'(cap)) begin
            burst_len = 9'(remaining);
        end else begin
            burst_len = cap;
        end
    end

endmodule

// File: rtl/axi_burst_reader.sv
// Splits a read command into AXI4 AR bursts and forwards R beats as an output stream.
module axi_burst_reader
    import axi_burst_pkg::*;
#(
    parameter int unsigned C_AXI_ADDR_WIDTH  = 32,
    parameter int unsigned C_AXI_DATA_WIDTH  = 32,
    parameter int unsigned C_MAX_BURST_LEN   = 256,
    parameter int unsigned C_LEN_WIDTH       = 16,
    parameter int unsigned C_MAX_OUTSTANDING = 4
) (
    input  logic                        aclk,
    input  logic                        arst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_LEN_WIDTH-1:0]      cmd_beats,
    input  logic                        cmd_fixed,
    axi_burst_reader_if.master          axi,
    output logic [C_AXI_DATA_WIDTH-1:0] dout_data,
    output logic                        dout_last,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned SizeLog = 32'(calc_arsize(C_AXI_DATA_WIDTH));
    localparam logic [C_AXI_ADDR_WIDTH-1:0] AddrMask =
        C_AXI_ADDR_WIDTH'((C_AXI_DATA_WIDTH / 8) - 1);
    localparam int unsigned OutW = $clog2(C_MAX_OUTSTANDING + 1);

    state_e                      state_q, state_d;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_LEN_WIDTH-1:0]      remaining_q;
    logic                        fixed_q;
    logic [OutW-1:0]             outstanding_q;
    logic                        err_q;
    logic [8:0]                  burst_len;
    logic                        cmd_hs, ar_hs, r_hs, r_last_hs;

    assign cmd_hs    = cmd_valid && cmd_ready;
    assign ar_hs     = axi.arvalid && axi.arready;
    assign r_hs      = axi.rvalid && axi.rready;
    assign r_last_hs = r_hs && axi.rlast;

    axi_burst_len_calc #(
        .C_AXI_DATA_WIDTH (C_AXI_DATA_WIDTH),
        .C_MAX_BURST_LEN  (C_MAX_BURST_LEN),
        .C_LEN_WIDTH      (C_LEN_WIDTH)
    ) u_len_calc (
        .addr_offset (addr_q[11:0]),
        .remaining   (remaining_q),
        .fixed       (fixed_q),
        .burst_len   (burst_len)
    );

    // State register.
    always_ff @(posedge aclk) begin
        if (arst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next-state logic; the final AR handshake empties remaining and moves to DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cmd_hs) state_d = (cmd_beats == '0) ? StDone : StIssue;
            StIssue: if (ar_hs && (remaining_q == C_LEN_WIDTH'(burst_len))) state_d = StDrain;
            StDrain: if (outstanding_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; R is a zero-latency pass-through only while a command is in flight.
    always_comb begin
        cmd_ready   = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        dout_valid  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            StIssue: begin
                axi.arvalid = outstanding_q < OutW'(C_MAX_OUTSTANDING);
                axi.rready  = dout_ready;
                dout_valid  = axi.rvalid;
            end
            StDrain: begin
                axi.rready = dout_ready;
                dout_valid = axi.rvalid;
            end
            StDone:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Command address/length bookkeeping, advanced on each AR handshake.
    always_ff @(posedge aclk) begin
        if (arst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            fixed_q     <= 1'b0;
        end else if (cmd_hs) begin
            addr_q      <= cmd_addr & ~AddrMask;
            remaining_q <= cmd_beats;
            fixed_q     <= cmd_fixed;
        end else if (ar_hs) begin
            remaining_q <= remaining_q - C_LEN_WIDTH'(burst_len);
            if (!fixed_q) addr_q <= addr_q + (C_AXI_ADDR_WIDTH'(burst_len) << SizeLog);
        end
    end

    // Bursts issued but not yet closed by rlast.
    always_ff @(posedge aclk) begin
        if (arst) begin
            outstanding_q <= '0;
        end else if (ar_hs && !r_last_hs) begin
            outstanding_q <= outstanding_q + OutW'(1);
        end else if (!ar_hs && r_last_hs) begin
            outstanding_q <= outstanding_q - OutW'(1);
        end
    end

    // Sticky error from any non-OKAY response, cleared when a new command is taken.
    always_ff @(posedge aclk) begin
        if (arst)                             err_q <= 1'b0;
        else if (cmd_hs)                      err_q <= 1'b0;
        else if (r_hs && axi.rresp != 2'b00)  err_q <= 1'b1;
    end

    assign axi.araddr   = addr_q;
    assign axi.arlen    = (burst_len == '0) ? 8'd0 : 8'(burst_len - 9'd1);
    assign axi.arsize   = calc_arsize(C_AXI_DATA_WIDTH);
    assign axi.arburst  = fixed_q ? BurstFixed : BurstIncr;
    assign axi.arlock   = LockNormal;
    assign axi.arcache  = CacheNormNcBuf;
    assign axi.arprot   = ProtDefault;
    assign axi.arqos    = QosDefault;
    assign axi.arregion = RegionDefault;

    // R returns in order, so in DRAIN with one burst left the beats are the final burst's.
    assign dout_data = axi.rdata;
    assign dout_last = axi.rlast && (state_q == StDrain) && (outstanding_q == OutW'(1));
    assign err       = err_q;

endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench: randomized AXI slave plus a burst-splitting reference model of the reader.
module tb_axi_burst_reader;

    localparam int unsigned MaxBurst = 256;
    localparam int unsigned MaxOut   = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } burst_t;

    logic        aclk = 1'b0;
    logic        arst;
    logic        cmd_valid, cmd_ready, cmd_fixed;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic [31:0] dout_data;
    logic        dout_last, dout_valid, dout_ready;
    logic        busy, done, err;

    axi_burst_reader_if #(.C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32)) axi ();

    axi_burst_reader #(
        .C_AXI_ADDR_WIDTH  (32),
        .C_AXI_DATA_WIDTH  (32),
        .C_MAX_BURST_LEN   (MaxBurst),
        .C_LEN_WIDTH       (16),
        .C_MAX_OUTSTANDING (MaxOut)
    ) dut (
        .aclk       (aclk),
        .arst       (arst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_beats  (cmd_beats),
        .cmd_fixed  (cmd_fixed),
        .axi        (axi),
        .dout_data  (dout_data),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 aclk = ~aclk;

    int          n_vec = 0;
    int          n_err = 0;

    // Written by the slave process only.
    burst_t      ar_seen[$];
    logic [31:0] dout_seen[$];
    logic        last_seen[$];
    int unsigned done_cnt = 0;
    int unsigned r_total = 0;

    // Written by the main sequence only.
    int unsigned err_at = 32'hFFFF_FFFF;
    int          ready_mode = 1;
    bit          ar_rand = 1'b0;
    bit          r_rand = 1'b0;

    // Expected transaction of the command in flight.
    burst_t      exp_ar[$];
    logic [31:0] exp_d[$];
    bit          exp_err;
    int unsigned ar0, d0, dn0;

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int unsigned j);
        return (a * 32'h9E37_79B1) ^ (32'(j) << 24);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AXI slave: logs handshakes at negedge, drives new values just after posedge.
    initial begin : slave
        bit          ar_fire, r_fire, r_last, rst_seen;
        burst_t      b;
        int unsigned r_beat;
        r_beat      = 0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        dout_ready  = 1'b1;
        forever begin
            @(negedge aclk);
            rst_seen = arst;
            ar_fire  = axi.arvalid && axi.arready;
            r_fire   = axi.rvalid && axi.rready;
            r_last   = axi.rlast;
            if (!rst_seen) begin
                if (ar_fire) begin
                    b = '{addr: axi.araddr, len: axi.arlen, burst: axi.arburst};
                    ar_seen.push_back(b);
                end
                if (dout_valid && dout_ready) begin
                    dout_seen.push_back(dout_data);
                    last_seen.push_back(dout_last);
                end
                if (done) done_cnt++;
            end
            @(posedge aclk);
            #1;
            if (rst_seen) begin
                r_beat      = 0;
                axi.arready = 1'b0;
                axi.rvalid  = 1'b0;
                axi.rlast   = 1'b0;
            end else begin
                if (r_fire) begin
                    r_total++;
                    r_beat = r_last ? 0 : r_beat + 1;
                end
                axi.arready = ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (axi.rvalid && !r_fire) begin
                    // an offered beat stays put until accepted
                end else if (ar_seen.size() > 0 && pend_count() > 0 &&
                             (!r_rand || $urandom_range(0, 3) != 0)) begin
                    b = ar_seen[ar_seen.size() - pend_count()];
                    axi.rvalid = 1'b1;
                    axi.rdata  = beat_data((b.burst == 2'b00) ? b.addr : b.addr + 4 * r_beat,
                                           r_beat);
                    axi.rlast  = (r_beat == 32'(b.len));
                    axi.rresp  = (r_total == err_at) ? 2'b10 : 2'b00;
                end else begin
                    axi.rvalid = 1'b0;
                    axi.rlast  = 1'b0;
                end
                case (ready_mode)
                    0:       dout_ready = 1'b0;
                    1:       dout_ready = 1'b1;
                    default: dout_ready = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    end

    // Bursts accepted since the last reset and not yet closed by rlast.
    int unsigned closed_bursts = 0;
    int unsigned reset_base = 0;
    always @(negedge aclk) begin
        if (arst) reset_base <= ar_seen.size();
        else if (axi.rvalid && axi.rready && axi.rlast) closed_bursts <= closed_bursts + 1;
        if (arst) closed_bursts <= 0;
    end

    function automatic int unsigned pend_count();
        return ar_seen.size() - reset_base - closed_bursts;
    endfunction

    // Reference model: split the command into bursts by the AXI rules, then accept it.
    task automatic start_cmd(input logic [31:0] addr, input int beats, input bit fixed,
                             input int err_off);
        int unsigned a, rem, n;
        bit          got;
        exp_ar.delete();
        exp_d.delete();
        a   = addr & ~32'h3;
        rem = beats;
        while (rem > 0) begin
            if (fixed) begin
                n = (rem < 16) ? rem : 16;
            end else begin
                n = (4096 - (a % 4096)) / 4;
                if (n > MaxBurst) n = MaxBurst;
                if (rem < n) n = rem;
            end
            exp_ar.push_back('{addr: a, len: 8'(n - 1), burst: fixed ? 2'b00 : 2'b01});
            for (int j = 0; j < int'(n); j++) exp_d.push_back(beat_data(fixed ? a : a + 4 * j, j));
            rem -= n;
            if (!fixed) a += 4 * n;
        end
        exp_err = (err_off >= 0) && (err_off < beats);
        ar0     = ar_seen.size();
        d0      = dout_seen.size();
        dn0     = done_cnt;
        err_at  = (err_off >= 0) ? r_total + err_off : 32'hFFFF_FFFF;
        cmd_addr  = addr;
        cmd_beats = 16'(beats);
        cmd_fixed = fixed;
        cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge aclk);
            got = cmd_ready;
            @(posedge aclk);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", got, 1);
        check("err_clear_on_accept", err, 0);
    endtask

    task automatic finish_cmd();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge aclk);
            got = done;
        end
        check("done_seen", got, 1);
        repeat (2) @(posedge aclk);
        #1;
        check("done_once", done_cnt - dn0, 1);
        check("done_low", done, 0);
        check("busy_idle", busy, 0);
        check("ar_count", ar_seen.size() - ar0, exp_ar.size());
        for (int i = 0; i < exp_ar.size() && ar0 + i < ar_seen.size(); i++) begin
            check("ar_addr_len_burst", ar_seen[ar0 + i], exp_ar[i]);
            if (ar_seen[ar0 + i].burst == 2'b01)
                check("ar_no_4k_cross",
                      (ar_seen[ar0 + i].addr % 4096) + (ar_seen[ar0 + i].len + 1) * 4 <= 4096, 1);
        end
        check("beat_count", dout_seen.size() - d0, exp_d.size());
        for (int i = 0; i < exp_d.size() && d0 + i < dout_seen.size(); i++)
            check("beat_data_last", {dout_seen[d0 + i], last_seen[d0 + i]},
                  {exp_d[i], i == exp_d.size() - 1});
        check("err_sticky", err, exp_err);
    endtask

    task automatic run_cmd(input logic [31:0] addr, input int beats, input bit fixed,
                           input int err_off);
        start_cmd(addr, beats, fixed, err_off);
        finish_cmd();
    endtask

    initial begin : main
        arst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        cmd_fixed = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_araddr", axi.araddr, 0);
        check("rst_arlen", axi.arlen, 0);
        arst = 1'b0;
        check("arsize", axi.arsize, 2);
        check("arcache", axi.arcache, 3);
        check("arlock_prot_qos_region",
              {axi.arlock, axi.arprot, axi.arqos, axi.arregion}, 0);

        // Directed: page split, 4 KB crossing, FIXED split, empty command.
        run_cmd(32'h0000_1000, 300, 1'b0, -1);
        run_cmd(32'h0000_0FF0, 8, 1'b0, -1);
        run_cmd(32'h0000_0040, 20, 1'b1, -1);
        run_cmd(32'h0000_0200, 0, 1'b0, -1);

        // SLVERR on beat 5 of 16, then the next accept must clear err.
        run_cmd(32'h0000_2000, 16, 1'b0, 4);
        run_cmd(32'h0000_2100, 4, 1'b0, -1);

        // Outstanding limit: sink stalled, so no rlast ever arrives.
        ready_mode = 0;
        start_cmd(32'h0000_0000, 1100, 1'b0, -1);
        repeat (40) @(posedge aclk);
        #1;
        check("outstanding_ar_count", ar_seen.size() - ar0, MaxOut);
        check("outstanding_arvalid", axi.arvalid, 0);
        check("outstanding_busy", busy, 1);
        ready_mode = 2;
        finish_cmd();

        // Reset mid-ISSUE, then a fresh command must still run cleanly.
        ar_rand = 1'b1;
        r_rand  = 1'b1;
        start_cmd(32'h0000_3000, 1100, 1'b0, -1);
        repeat (3) @(posedge aclk);
        #1;
        arst = 1'b1;
        @(posedge aclk);
        #1;
        arst = 1'b0;
        check("midrst_arvalid", axi.arvalid, 0);
        check("midrst_rready", axi.rready, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_busy", busy, 0);
        repeat (2) @(posedge aclk);
        #1;
        run_cmd(32'h0000_3000, 40, 1'b0, -1);

        // Randomized commands with random handshake timing.
        for (int k = 0; k < 6; k++) begin
            logic [31:0] ra;
            int          rb, re;
            bit          rf;
            ra = $urandom & 32'h0000_FFFF;
            rb = $urandom_range(1, 600);
            rf = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rb - 1)) : -1;
            run_cmd(ra, rb, rf, re);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_burst_reader.md
AXI_BURST_READER -- requirements
Module: axi_burst_reader

Interface
REQ-001 C_AXI_ADDR_WIDTH, 32, AXI address width.
REQ-002 C_AXI_DATA_WIDTH, 32, AXI data width; power of two, 32..512.
REQ-003 C_MAX_BURST_LEN, 256, max beats per INCR burst; power of two, 2..256.
REQ-004 C_LEN_WIDTH, 16, width of command beat count.
REQ-005 C_MAX_OUTSTANDING, 4, max AR bursts issued without final rlast; 1..16.
REQ-006 aclk  in  1  sole clock; all logic on rising edge.
REQ-007 arst  in  1  reset, synchronous, active-high.
REQ-008 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-009 cmd_addr  in  C_AXI_ADDR_WIDTH  start byte address; low log2(C_AXI_DATA_WIDTH/8) bits forced to zero.
REQ-010 cmd_beats  in  C_LEN_WIDTH  total beats to read.
REQ-011 cmd_fixed  in  1  1 = FIXED burst, 0 = INCR.
REQ-012 axi_araddr, axi_arlen[7:0], axi_arsize[2:0], axi_arburst[1:0], axi_arlock[1:0], axi_arcache[3:0], axi_arprot[2:0], axi_arqos[3:0], axi_arregion[3:0], axi_arvalid  out; axi_arready  in: AXI4 read address channel.
REQ-013 axi_rdata, axi_rresp[1:0], axi_rlast, axi_rvalid  in; axi_rready  out: AXI4 read data channel.
REQ-014 dout_data  out  C_AXI_DATA_WIDTH; dout_last, dout_valid  out  1; dout_ready  in  1: output stream.
REQ-015 busy  out  1; done  out  1 (one-cycle pulse); err  out  1 (sticky).

Function
REQ-016 Constants: arsize = log2(C_AXI_DATA_WIDTH/8); arlock 0; arcache 3 (normal non-cacheable bufferable); arprot 0; arqos 0; arregion 0; arburst 1 (INCR) or 0 (FIXED) from the latched cmd_fixed.
REQ-017 FSM states IDLE, ISSUE, DRAIN, DONE; cmd_ready = 1 only in IDLE.
REQ-018 IDLE: on cmd handshake latch addr/beats/mode, clear err; beats = 0 -> DONE, else ISSUE.
REQ-019 Burst length INCR = min(remaining, C_MAX_BURST_LEN, beats to next 4 KB boundary); FIXED = min(remaining, 16); axi_arlen = length - 1.
REQ-020 ISSUE: axi_arvalid = 1 while outstanding < C_MAX_OUTSTANDING; araddr/arlen stable until arready.
REQ-021 On AR handshake: remaining -= length; INCR address += length × bytes per beat; FIXED address unchanged; remaining becomes 0 -> DRAIN.
REQ-022 Outstanding counter: +1 on AR handshake, -1 on R handshake with rlast; both in one cycle -> unchanged.
REQ-023 R pass-through, zero latency: dout_data = axi_rdata, dout_valid = axi_rvalid, axi_rready = dout_ready, in ISSUE/DRAIN only; axi_rready = 0 in IDLE/DONE.
REQ-024 dout_last = axi_rlast and beat belongs to the final burst of the command.
REQ-025 Any R handshake with rresp ≠ 0 sets err; data still forwarded; err held until next cmd accept.
REQ-026 DRAIN: outstanding = 0 -> DONE; DONE: done = 1 for one cycle -> IDLE.
REQ-027 busy = 1 in ISSUE, DRAIN, DONE.

Reset
REQ-028 On arst: state IDLE, outstanding 0, remaining 0, cmd_ready 1, axi_arvalid 0, axi_rready 0, busy 0, done 0, err 0, araddr 0, arlen 0; takes effect mid-operation; the slave is reset by the same system reset.

Structure
REQ-029 Package axi_burst_pkg holds burst encodings (FIXED 0, INCR 1), lock/cache/prot constants, FSM state enum, and function computing arsize from data width.
REQ-030 Sub-module axi_burst_len_calc: combinational burst length from address, remaining, mode and parameters.

Verification (C_AXI_DATA_WIDTH = 32 unless stated)
REQ-031 addr 0x1000, beats 300, INCR -> AR (0x1000, len 255), (0x1400, len 43); 300 dout beats; dout_last on beat 300 only; one done pulse.
REQ-032 addr 0x0FF0, beats 8, INCR -> AR (0x0FF0, len 3), (0x1000, len 3); no burst crosses 4 KB.
REQ-033 addr 0x40, beats 20, FIXED -> AR (0x40, len 15, burst 0), (0x40, len 3, burst 0).
REQ-034 C_MAX_BURST_LEN 8, C_MAX_OUTSTANDING 2, beats 64, arready 1, dout_ready 0 -> exactly 2 AR handshakes, then arvalid 0 until the first rlast.
REQ-035 SLVERR on beat 5 of 16 -> err = 1 from next cycle, 16 beats forwarded, err = 0 after next cmd accept.
REQ-036 arst for 1 cycle mid-ISSUE -> next cycle arvalid 0, rready 0, cmd_ready 1, busy 0; a new command runs correctly.
